// File: rtl/bsg_mem_1rw_sync_mask_write_bit_seg_pkg.sv
// Shared helpers for the segmented bit-masked single-port memory.
package bsg_mem_1rw_sync_mask_write_bit_seg_pkg;

    // Address width that stays at least 1 bit wide, even for a single-entry array.
    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bsg_mem_1rw_sync_mask_write_bit_seg_bank.sv
// Single-port synchronous memory with per-bit write mask.
// Used as the wide backing array of the segmented memory. The read data
// register only changes on a read, so it already holds the last read value.
// latch_last_read_p is kept so this module can be swapped for the library bank.
module bsg_mem_1rw_sync_mask_write_bit
    import bsg_mem_1rw_sync_mask_write_bit_seg_pkg::*;
#(
    parameter int width_p           = 32,
    parameter int els_p             = 16,
    parameter int latch_last_read_p = 0,
    localparam int lg_els_lp        = safe_clog2(els_p)
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [width_p-1:0]   data_i,
    input  logic [lg_els_lp-1:0] addr_i,
    input  logic                 v_i,
    input  logic [width_p-1:0]   w_mask_i,
    input  logic                 w_i,
    output logic [width_p-1:0]   data_o
);

    logic [width_p-1:0] mem_r [els_p];
    logic [width_p-1:0] data_r;
    logic               addr_ok;

    // Writes to out-of-range addresses are dropped; reads return 0.
    assign addr_ok = (int'(addr_i) < els_p);

    // Array update: the contents are never reset, and an access made
    // while reset is asserted is dropped.
    always_ff @(posedge clk_i) begin
        if (!reset_i && v_i && w_i && addr_ok)
            mem_r[addr_i] <= (data_i & w_mask_i) | (mem_r[addr_i] & ~w_mask_i);
    end

    // Read register: whole-row read, visible one cycle after the request.
    always_ff @(posedge clk_i) begin
        if (!reset_i && v_i && !w_i)
            data_r <= addr_ok ? mem_r[addr_i] : '0;
    end

    assign data_o = data_r;

endmodule

// File: rtl/bsg_mem_1rw_sync_mask_write_bit_seg.sv
// Segmented single-port synchronous memory with bit-masked writes.
// The row is split into num_segments_p equal segments, each with its own
// valid strobe; address and read/write select are shared. Behaves like
// num_segments_p independent banks but uses one wide backing array.
module bsg_mem_1rw_sync_mask_write_bit_seg
    import bsg_mem_1rw_sync_mask_write_bit_seg_pkg::*;
#(
    parameter int width_p           = 32,
    parameter int els_p             = 16,
    parameter int num_segments_p    = 4,
    parameter int latch_last_read_p = 0,
    localparam int lg_els_lp        = safe_clog2(els_p)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [num_segments_p-1:0] v_i,
    input  logic                      w_i,
    input  logic [lg_els_lp-1:0]      addr_i,
    input  logic [width_p-1:0]        data_i,
    input  logic [width_p-1:0]        w_mask_i,
    output logic [width_p-1:0]        data_o
);

    localparam int seg_w_lp = width_p / num_segments_p;

    if (width_p % num_segments_p != 0) begin : g_bad_width
        $error("width_p (%0d) must be divisible by num_segments_p (%0d)", width_p, num_segments_p);
    end

    logic [width_p-1:0]                      bank_mask;
    logic [width_p-1:0]                      bank_data;
    logic [num_segments_p-1:0][seg_w_lp-1:0] bank_seg;
    logic [num_segments_p-1:0][seg_w_lp-1:0] data_seg;
    logic [num_segments_p-1:0]               rd_v_r;

    // Unselected segments get a zero mask so they are never written.
    for (genvar i = 0; i < num_segments_p; i++) begin : g_mask
        assign bank_mask[i*seg_w_lp +: seg_w_lp] =
            w_mask_i[i*seg_w_lp +: seg_w_lp] & {seg_w_lp{v_i[i]}};
    end

    bsg_mem_1rw_sync_mask_write_bit #(
        .width_p           (width_p),
        .els_p             (els_p),
        .latch_last_read_p (0)
    ) bank (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .data_i   (data_i),
        .addr_i   (addr_i),
        .v_i      (|v_i),
        .w_mask_i (bank_mask),
        .w_i      (w_i),
        .data_o   (bank_data)
    );

    assign bank_seg = bank_data;

    // Per-segment read-valid: marks which segments of bank_data are fresh.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) rd_v_r <= '0;
        else         rd_v_r <= v_i & {num_segments_p{~w_i}};
    end

    if (latch_last_read_p != 0) begin : g_latch
        for (genvar i = 0; i < num_segments_p; i++) begin : g_seg
            logic [seg_w_lp-1:0] latch_r;

            // Capture a segment's fresh read data; hold it through writes and idles.
            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i)        latch_r <= '0;
                else if (rd_v_r[i]) latch_r <= bank_seg[i];
            end

            assign data_seg[i] = rd_v_r[i] ? bank_seg[i] : latch_r;
        end
    end else begin : g_nolatch
        // Segments that were not just read are undefined to the consumer;
        // drive them to 0 so stale rows do not leak out.
        for (genvar i = 0; i < num_segments_p; i++) begin : g_seg
            assign data_seg[i] = rd_v_r[i] ? bank_seg[i] : '0;
        end
    end

    assign data_o = data_seg;

endmodule

// File: tb/tb_bsg_mem_1rw_sync_mask_write_bit_seg.sv
// Directed bench for the segmented bit-masked memory, latch 0 and latch 1.
module tb_bsg_mem_1rw_sync_mask_write_bit_seg;

    logic        clk;
    logic        reset_i;
    logic [3:0]  v_i;
    logic        w_i;
    logic [3:0]  addr_i;
    logic [31:0] data_i;
    logic [31:0] w_mask_i;
    logic [31:0] data0;
    logic [31:0] data1;

    int checks = 0;
    int errors = 0;

    bsg_mem_1rw_sync_mask_write_bit_seg #(
        .width_p(32), .els_p(16), .num_segments_p(4), .latch_last_read_p(0)
    ) dut0 (
        .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .w_i(w_i), .addr_i(addr_i),
        .data_i(data_i), .w_mask_i(w_mask_i), .data_o(data0)
    );

    bsg_mem_1rw_sync_mask_write_bit_seg #(
        .width_p(32), .els_p(16), .num_segments_p(4), .latch_last_read_p(1)
    ) dut1 (
        .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .w_i(w_i), .addr_i(addr_i),
        .data_i(data_i), .w_mask_i(w_mask_i), .data_o(data1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [3:0] v, input logic [3:0] a,
                      input logic [31:0] d, input logic [31:0] m);
        v_i = v; w_i = 1'b1; addr_i = a; data_i = d; w_mask_i = m;
        tick();
        v_i = 4'h0; w_i = 1'b0;
    endtask

    task automatic rd(input logic [3:0] v, input logic [3:0] a);
        v_i = v; w_i = 1'b0; addr_i = a;
        tick();
        v_i = 4'h0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (data1 !== 32'h0) begin
            errors++;
            $display("FAIL reset_latch: got %h expected %h", data1, 32'h0);
        end
        @(negedge clk);
        reset_i = 1'b0;
        tick();
        checks++;
        if (data1 !== 32'h0) begin
            errors++;
            $display("FAIL reset_idle: got %h expected %h", data1, 32'h0);
        end
    endtask

    task automatic test_full_write_read();
        wr(4'hf, 4'd3, 32'h12345678, 32'hffffffff);
        rd(4'hf, 4'd3);
        checks++;
        if (data0 !== 32'h12345678) begin
            errors++;
            $display("FAIL full_rd_l0: got %h expected %h", data0, 32'h12345678);
        end
        checks++;
        if (data1 !== 32'h12345678) begin
            errors++;
            $display("FAIL full_rd_l1: got %h expected %h", data1, 32'h12345678);
        end
    endtask

    // seg0: 78 & ~11 = 68, seg2: 34 & ~cd = 30, segs 1,3 untouched.
    task automatic test_seg_masked_write();
        wr(4'b0101, 4'd3, 32'h0, 32'habcdef11);
        rd(4'hf, 4'd3);
        checks++;
        if (data0 !== 32'h12305668) begin
            errors++;
            $display("FAIL seg_mask_l0: got %h expected %h", data0, 32'h12305668);
        end
        checks++;
        if (data1 !== 32'h12305668) begin
            errors++;
            $display("FAIL seg_mask_l1: got %h expected %h", data1, 32'h12305668);
        end
        // Only seg1 is valid; the full mask must not reach the other segments.
        wr(4'hf, 4'd7, 32'h0, 32'hffffffff);
        wr(4'b0010, 4'd7, 32'hffffffff, 32'hffffffff);
        rd(4'hf, 4'd7);
        checks++;
        if (data1 !== 32'h0000ff00) begin
            errors++;
            $display("FAIL seg_gate: got %h expected %h", data1, 32'h0000ff00);
        end
    endtask

    task automatic test_partial_read_latch();
        wr(4'hf, 4'd5, 32'hdeadbeef, 32'hffffffff);
        rd(4'hf, 4'd5);
        checks++;
        if (data1 !== 32'hdeadbeef) begin
            errors++;
            $display("FAIL part_setup: got %h expected %h", data1, 32'hdeadbeef);
        end
        rd(4'b0001, 4'd3);
        checks++;
        if (data1 !== 32'hdeadbe68) begin
            errors++;
            $display("FAIL part_rd_l1: got %h expected %h", data1, 32'hdeadbe68);
        end
        checks++;
        if (data0[7:0] !== 8'h68) begin
            errors++;
            $display("FAIL part_rd_l0: got %h expected %h", data0[7:0], 8'h68);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (data1 !== 32'hdeadbe68) begin
                errors++;
                $display("FAIL part_hold%0d: got %h expected %h", i, data1, 32'hdeadbe68);
            end
        end
        wr(4'hf, 4'd5, 32'h0, 32'hffffffff);
        checks++;
        if (data1 !== 32'hdeadbe68) begin
            errors++;
            $display("FAIL part_hold_wr: got %h expected %h", data1, 32'hdeadbe68);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp [3];
        exp[0] = 32'ha5a50f0f;
        exp[1] = 32'h3c3c9696;
        exp[2] = 32'h0123ffff;
        wr(4'hf, 4'd0, 32'ha5a50f0f, 32'hffffffff);
        wr(4'hf, 4'd1, 32'h3c3c9696, 32'hffffffff);
        wr(4'hf, 4'd2, 32'h01234567, 32'hffffffff);
        wr(4'hf, 4'd2, 32'hffffffff, 32'h0000ffff);
        for (int i = 0; i < 3; i++) begin
            v_i = 4'hf; w_i = 1'b0; addr_i = 4'(i);
            tick();
            checks++;
            if (data0 !== exp[i]) begin
                errors++;
                $display("FAIL b2b_l0_%0d: got %h expected %h", i, data0, exp[i]);
            end
        end
        v_i = 4'b1100; w_i = 1'b0; addr_i = 4'd0;
        tick();
        v_i = 4'b0011; addr_i = 4'd1;
        tick();
        v_i = 4'h0;
        checks++;
        if (data1 !== 32'ha5a59696) begin
            errors++;
            $display("FAIL b2b_mix: got %h expected %h", data1, 32'ha5a59696);
        end
    endtask

    task automatic test_reset_mid();
        rd(4'hf, 4'd3);
        checks++;
        if (data1 !== 32'h12305668) begin
            errors++;
            $display("FAIL rst_pre: got %h expected %h", data1, 32'h12305668);
        end
        #2 reset_i = 1'b1;
        #1;
        checks++;
        if (data1 !== 32'h0) begin
            errors++;
            $display("FAIL rst_async: got %h expected %h", data1, 32'h0);
        end
        // Write issued while reset is high must be dropped.
        v_i = 4'hf; w_i = 1'b1; addr_i = 4'd3; data_i = 32'hffffffff; w_mask_i = 32'hffffffff;
        tick();
        v_i = 4'h0; w_i = 1'b0;
        reset_i = 1'b0;
        rd(4'b0001, 4'd3);
        checks++;
        if (data1 !== 32'h00000068) begin
            errors++;
            $display("FAIL rst_part: got %h expected %h", data1, 32'h00000068);
        end
        rd(4'hf, 4'd3);
        checks++;
        if (data1 !== 32'h12305668) begin
            errors++;
            $display("FAIL rst_keep_l1: got %h expected %h", data1, 32'h12305668);
        end
        checks++;
        if (data0 !== 32'h12305668) begin
            errors++;
            $display("FAIL rst_keep_l0: got %h expected %h", data0, 32'h12305668);
        end
    endtask

    initial begin
        reset_i  = 1'b1;
        v_i      = 4'h0;
        w_i      = 1'b0;
        addr_i   = 4'h0;
        data_i   = 32'h0;
        w_mask_i = 32'habcdef11;
        test_reset();
        test_full_write_read();
        test_seg_masked_write();
        test_partial_read_latch();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
